// File: rtl/alu_mdu_if.sv
// alu_mdu_if: operand/result bundle between the control unit and alu_mdu.
//   master : drives start, ALUCtrl, A, B; observes result, flags, handshake and HI/LO.
//   slave  : the ALU/MDU itself.
interface alu_mdu_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic [4:0]       ALUCtrl;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] result;
   logic             Zero;
   logic             Sign;
   logic             O;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic             stall;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, ALUCtrl, A, B,
      input  result, Zero, Sign, O, busy, done, div_zero, stall, hi, lo
   );

   modport slave (
      input  start, ALUCtrl, A, B,
      output result, Zero, Sign, O, busy, done, div_zero, stall, hi, lo
   );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: combinational ALU plus iterative multiply/divide unit with HI/LO registers.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_mdu_if slave
//          start/ALUCtrl/A/B in; result/Zero/Sign/O combinational out;
//          busy/done/div_zero/stall MDU handshake; hi/lo architectural registers.
// MULT*/DIV* run IDLE -> CALC (WIDTH steps on magnitudes) -> FIX (sign fix, HI/LO write) -> IDLE.
module alu_mdu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input logic     clk,
   input logic     rst,
   alu_mdu_if.slave bus
);

   localparam logic [4:0] OpAdd   = 5'b00000;
   localparam logic [4:0] OpAddu  = 5'b00001;
   localparam logic [4:0] OpSub   = 5'b00010;
   localparam logic [4:0] OpSubu  = 5'b00011;
   localparam logic [4:0] OpAnd   = 5'b00100;
   localparam logic [4:0] OpOr    = 5'b00101;
   localparam logic [4:0] OpNor   = 5'b00110;
   localparam logic [4:0] OpXor   = 5'b00111;
   localparam logic [4:0] OpSlt   = 5'b01000;
   localparam logic [4:0] OpSltu  = 5'b01001;
   localparam logic [4:0] OpSll   = 5'b01010;
   localparam logic [4:0] OpSrl   = 5'b01011;
   localparam logic [4:0] OpSra   = 5'b01100;
   localparam logic [4:0] OpLui   = 5'b01101;
   localparam logic [4:0] OpMult  = 5'b10000;
   localparam logic [4:0] OpMultu = 5'b10001;
   localparam logic [4:0] OpDiv   = 5'b10010;
   localparam logic [4:0] OpDivu  = 5'b10011;
   localparam logic [4:0] OpMfhi  = 5'b10100;
   localparam logic [4:0] OpMflo  = 5'b10101;
   localparam logic [4:0] OpMthi  = 5'b10110;
   localparam logic [4:0] OpMtlo  = 5'b10111;

   localparam logic [SHW:0] LastCnt = (SHW+1)'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e             state_q, state_d;
   logic [SHW:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]   work_hi_q, work_hi_d;   // partial product high / running remainder
   logic [WIDTH-1:0]   work_lo_q, work_lo_d;   // multiplier bits / dividend-then-quotient
   logic [WIDTH-1:0]   opb_q, opb_d;           // |multiplicand| or |divisor|
   logic [WIDTH-1:0]   dividend_q, dividend_d; // raw A, returned in HI on divide-by-zero
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;   // negate product / quotient
   logic               neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
   logic               bzero_q, bzero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;

   // ---------------- combinational ALU ----------------
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum, diff, lui, alu_res;
   logic             add_ovf, sub_ovf, ovf;

   assign shamt   = bus.A[SHW-1:0];
   assign sum     = bus.A + bus.B;
   assign diff    = bus.A - bus.B;
   assign add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) & (sum[WIDTH-1] != bus.A[WIDTH-1]);
   assign sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) & (diff[WIDTH-1] != bus.A[WIDTH-1]);

   if (WIDTH >= 16) begin : g_lui
      assign lui = WIDTH'(bus.B[15:0]) << (WIDTH - 16);
   end else begin : g_no_lui
      assign lui = '0;
   end

   always_comb begin
      alu_res = '0;
      ovf     = 1'b0;
      case (bus.ALUCtrl)
         OpAdd:  begin alu_res = sum;  ovf = add_ovf; end
         OpAddu: alu_res = sum;
         OpSub:  begin alu_res = diff; ovf = sub_ovf; end
         OpSubu: alu_res = diff;
         OpAnd:  alu_res = bus.A & bus.B;
         OpOr:   alu_res = bus.A | bus.B;
         OpNor:  alu_res = ~(bus.A | bus.B);
         OpXor:  alu_res = bus.A ^ bus.B;
         OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
         OpSll:  alu_res = bus.B << shamt;
         OpSrl:  alu_res = bus.B >> shamt;
         OpSra:  alu_res = $signed(bus.B) >>> shamt;
         OpLui:  alu_res = lui;
         OpMfhi: alu_res = hi_q;
         OpMflo: alu_res = lo_q;
         OpMthi, OpMtlo: alu_res = bus.A;
         default: alu_res = '0;
      endcase
   end

   assign bus.result = alu_res;
   assign bus.Zero   = (alu_res == '0);
   assign bus.Sign   = alu_res[WIDTH-1];
   assign bus.O      = ovf;

   // ---------------- multiply / divide unit ----------------
   logic             busy, mdu_op, accept, is_signed, a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, rem_sh, div_trial;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;

   assign busy      = (state_q != StIdle);
   assign mdu_op    = (bus.ALUCtrl[4:3] == 2'b10);
   assign accept    = bus.start & ~busy & mdu_op;
   assign is_signed = (bus.ALUCtrl == OpMult) | (bus.ALUCtrl == OpDiv);
   assign a_neg     = is_signed & bus.A[WIDTH-1];
   assign b_neg     = is_signed & bus.B[WIDTH-1];
   assign mag_a     = a_neg ? -bus.A : bus.A;
   assign mag_b     = b_neg ? -bus.B : bus.B;

   // Shift-add: add multiplicand when multiplier LSB set, then shift {carry,hi,lo} right.
   assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
   // Restoring divide: bring in next dividend bit, keep trial difference if non-negative.
   assign rem_sh    = {work_hi_q, work_lo_q[WIDTH-1]};
   assign div_trial = rem_sh - {1'b0, opb_q};
   assign prod_raw  = {work_hi_q, work_lo_q};
   assign prod_fix  = neg_res_q ? -prod_raw : prod_raw;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_hi_d  = work_hi_q;
      work_lo_d  = work_lo_q;
      opb_d      = opb_q;
      dividend_d = dividend_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      bzero_d    = bzero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               case (bus.ALUCtrl)
                  OpMult, OpMultu, OpDiv, OpDivu: begin
                     state_d    = StCalc;
                     cnt_d      = '0;
                     is_div_d   = bus.ALUCtrl[1];
                     neg_res_d  = a_neg ^ b_neg;
                     neg_rem_d  = a_neg;
                     bzero_d    = (bus.B == '0);
                     dividend_d = bus.A;
                     opb_d      = mag_b;
                     work_hi_d  = '0;
                     work_lo_d  = mag_a;
                  end
                  OpMthi:  hi_d = bus.A;
                  OpMtlo:  lo_d = bus.A;
                  default: ;
               endcase
            end
         end
         StCalc: begin
            if (is_div_q) begin
               work_hi_d = div_trial[WIDTH] ? rem_sh[WIDTH-1:0] : div_trial[WIDTH-1:0];
               work_lo_d = {work_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
            end else begin
               work_hi_d = mul_sum[WIDTH:1];
               work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (is_div_q && bzero_q) begin
               lo_d = '1;
               hi_d = dividend_q;
            end else if (is_div_q) begin
               lo_d = neg_res_q ? -work_lo_q : work_lo_q;
               hi_d = neg_rem_q ? -work_hi_q : work_hi_q;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            state_d    = StIdle;
            cnt_d      = '0;
            done_d     = 1'b1;
            div_zero_d = is_div_q & bzero_q;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         work_hi_q  <= '0;
         work_lo_q  <= '0;
         opb_q      <= '0;
         dividend_q <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         bzero_q    <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         work_hi_q  <= work_hi_d;
         work_lo_q  <= work_lo_d;
         opb_q      <= opb_d;
         dividend_q <= dividend_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         bzero_q    <= bzero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.busy     = busy;
   assign bus.stall    = busy & mdu_op;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized + directed bench for alu_mdu with a queue-based scoreboard.
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_alu_mdu;
   localparam int unsigned W = 32;

   localparam logic [4:0] OpAdd = 5'd0,  OpAddu = 5'd1,  OpSub = 5'd2,  OpSubu = 5'd3;
   localparam logic [4:0] OpAnd = 5'd4,  OpOr   = 5'd5,  OpNor = 5'd6,  OpXor  = 5'd7;
   localparam logic [4:0] OpSlt = 5'd8,  OpSltu = 5'd9,  OpSll = 5'd10, OpSrl  = 5'd11;
   localparam logic [4:0] OpSra = 5'd12, OpLui  = 5'd13;
   localparam logic [4:0] OpMult = 5'd16, OpMultu = 5'd17, OpDiv = 5'd18, OpDivu = 5'd19;
   localparam logic [4:0] OpMfhi = 5'd20, OpMflo = 5'd21, OpMthi = 5'd22, OpMtlo = 5'd23;

   logic clk = 1'b0;
   logic rst = 1'b0;

   alu_mdu_if #(.WIDTH(W)) bus_if ();

   alu_mdu #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        z, s, o, busy, stall;
      logic [31:0] hi, lo;
   } comb_t;

   typedef struct {
      logic [31:0] hi, lo;
      logic        dz;
      int          acc;
   } mdu_t;

   comb_t       comb_q[$];
   mdu_t        mdu_q[$];
   mdu_t        pend;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_timeouts = 0;
   logic        chk_comb = 1'b0;
   logic        end_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic comb_t model_comb(logic [4:0] c, logic [31:0] a, logic [31:0] b,
                                        logic eb);
      comb_t e;
      longint s;
      e = '{default: '0};
      s = 0;
      case (c)
         OpAdd: begin
            e.res = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            e.o = (s != longint'($signed(e.res)));
         end
         OpSub: begin
            e.res = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            e.o = (s != longint'($signed(e.res)));
         end
         OpAddu: e.res = a + b;
         OpSubu: e.res = a - b;
         OpAnd:  e.res = a & b;
         OpOr:   e.res = a | b;
         OpNor:  e.res = ~(a | b);
         OpXor:  e.res = a ^ b;
         OpSlt:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OpSltu: e.res = (a < b) ? 32'd1 : 32'd0;
         OpSll:  e.res = b << a[4:0];
         OpSrl:  e.res = b >> a[4:0];
         OpSra:  e.res = $signed(b) >>> a[4:0];
         OpLui:  e.res = {b[15:0], 16'h0000};
         OpMfhi: e.res = m_hi;
         OpMflo: e.res = m_lo;
         OpMthi, OpMtlo: e.res = a;
         default: e.res = '0;
      endcase
      e.z     = (e.res == 0);
      e.s     = e.res[31];
      e.busy  = eb;
      e.stall = eb && (c >= OpMult) && (c <= OpMtlo);
      e.hi    = m_hi;
      e.lo    = m_lo;
      return e;
   endfunction

   function automatic mdu_t model_mdu(logic [4:0] c, logic [31:0] a, logic [31:0] b);
      mdu_t r;
      longint p;
      longint unsigned pu;
      r = '{default: '0};
      case (c)
         OpMult: begin
            p = longint'($signed(a)) * longint'($signed(b));
            {r.hi, r.lo} = p;
         end
         OpMultu: begin
            pu = 64'(a) * 64'(b);
            {r.hi, r.lo} = pu;
         end
         default: begin
            if (b == 0) begin
               r.lo = 32'hFFFF_FFFF;
               r.hi = a;
               r.dz = 1'b1;
            end else if (c == OpDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r.lo = 32'h8000_0000;
               r.hi = 32'h0;
            end else if (c == OpDiv) begin
               r.lo = $signed(a) / $signed(b);
               r.hi = $signed(a) % $signed(b);
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
      endcase
      return r;
   endfunction

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin
      comb_t e;
      mdu_t  m;
      int    busy_run;
      busy_run = 0;
      forever begin
         @(negedge clk);
         if (rst) busy_run = 0;
         else if (bus_if.busy) busy_run++;
         if (chk_comb) begin
            chk_comb = 1'b0;
            if (comb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL comb_queue: got empty queue expected an entry");
            end else begin
               e = comb_q.pop_front();
               check("result", 64'(bus_if.result), 64'(e.res));
               check("flags_zso", 64'({bus_if.Zero, bus_if.Sign, bus_if.O}),
                     64'({e.z, e.s, e.o}));
               check("busy_stall", 64'({bus_if.busy, bus_if.stall}), 64'({e.busy, e.stall}));
               check("hi_lo_reg", {bus_if.hi, bus_if.lo}, {e.hi, e.lo});
            end
         end
         if (bus_if.done) begin
            if (mdu_q.size() == 0) begin
               check("unexpected_done", 64'(bus_if.done), 64'(0));
            end else begin
               m = mdu_q.pop_front();
               check("mdu_hi_lo", {bus_if.hi, bus_if.lo}, {m.hi, m.lo});
               check("div_zero", 64'(bus_if.div_zero), 64'(m.dz));
               check("done_latency", 64'(cyc - m.acc), 64'(W + 2));
               check("busy_cycles", 64'(busy_run), 64'(W + 1));
               busy_run = 0;
            end
         end
         if (end_req) begin
            check("wait_bound", 64'(n_timeouts), 64'(0));
            check("pending_mdu", 64'(mdu_q.size()), 64'(0));
            check("pending_comb", 64'(comb_q.size()), 64'(0));
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   task automatic apply(logic [4:0] c, logic [31:0] a, logic [31:0] b, logic st, logic chk,
                        logic eb);
      bus_if.ALUCtrl = c;
      bus_if.A       = a;
      bus_if.B       = b;
      bus_if.start   = st;
      if (chk) begin
         comb_q.push_back(model_comb(c, a, b, eb));
         chk_comb = 1'b1;
      end
   endtask

   task automatic drive(logic [4:0] c, logic [31:0] a, logic [31:0] b, logic st, logic chk,
                        logic eb);
      @(posedge clk);
      #1;
      apply(c, a, b, st, chk, eb);
   endtask

   task automatic idle(int n);
      repeat (n) drive(OpAddu, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic issue(logic [4:0] c, logic [31:0] a, logic [31:0] b);
      drive(c, a, b, 1'b1, 1'b0, 1'b0);
      pend = model_mdu(c, a, b);
      pend.acc = cyc;
      mdu_q.push_back(pend);
   endtask

   task automatic finish_op();
      drive(OpAddu, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100 && mdu_q.size() != 0; i++) @(negedge clk);
      if (mdu_q.size() != 0) begin
         n_timeouts++;
         mdu_q.delete();
      end
      m_hi = pend.hi;
      m_lo = pend.lo;
   endtask

   task automatic mt(logic [4:0] c, logic [31:0] a);
      drive(c, a, 32'h0, 1'b1, 1'b1, 1'b0);
      if (c == OpMthi) m_hi = a;
      else m_lo = a;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [4:0]  c;
      logic [31:0] a, b;
      apply(OpAddu, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 apply(OpAddu, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed ALU cases
      drive(OpAdd,  32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
      drive(OpAddu, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
      drive(OpSlt,  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
      drive(OpSltu, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
      drive(OpSra,  32'h4, 32'hF000_0000, 1'b0, 1'b1, 1'b0);
      drive(OpSub,  32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0);
      drive(OpLui,  32'h0, 32'h0000_ABCD, 1'b0, 1'b1, 1'b0);

      // MULT with an ignored second start and a stale MFHI while busy
      issue(OpMult, 32'hFFFF_FFFD, 32'h5);
      idle(3);
      drive(OpDiv, 32'd100, 32'd3, 1'b1, 1'b0, 1'b0);
      drive(OpMfhi, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      drive(OpMflo, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
      finish_op();
      drive(OpMfhi, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

      issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op();
      issue(OpDivu, 32'd100, 32'd7);                finish_op();
      issue(OpDiv, 32'hFFFF_FFF9, 32'h2);           finish_op();
      issue(OpDivu, 32'd5, 32'd0);                  finish_op();
      issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);   finish_op();
      issue(OpDiv, 32'hFFFF_FFF9, 32'h0);           finish_op();

      mt(OpMtlo, 32'h1234);
      drive(OpMflo, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Random ALU traffic, including move ops without start and undefined encodings
      for (int i = 0; i < 60; i++) begin
         c = 5'($urandom_range(0, 31));
         if (c >= OpMult && c <= OpDivu) c = c + 5'd4;
         a = pick_val();
         b = pick_val();
         drive(c, a, b, 1'b0, 1'b1, 1'b0);
      end

      // Random MDU traffic
      for (int i = 0; i < 14; i++) begin
         c = 5'(OpMult + 5'($urandom_range(0, 3)));
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         issue(c, a, b);
         finish_op();
         drive(OpMfhi, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
         drive(OpMflo, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      end

      // Reset in the middle of CALC discards the op and clears HI/LO
      mt(OpMthi, 32'hDEAD_BEEF);
      mt(OpMtlo, 32'hCAFE_F00D);
      drive(OpMultu, 32'h1234_5678, 32'h09AB_CDEF, 1'b1, 1'b0, 1'b0);
      idle(10);
      @(posedge clk);
      #1;
      rst  = 1'b1;
      m_hi = '0;
      m_lo = '0;
      apply(OpMfhi, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      drive(OpAddu, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      issue(OpMultu, 32'd6, 32'd7);
      finish_op();
      drive(OpMflo, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      idle(2);

      end_req = 1'b1;
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the single-cycle ALU, for the multi-cycle MIPS datapath.
- Keeps the full combinational ALU op set with corrected overflow and SLT semantics.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, a start/busy/done handshake and a stall output for the control unit.

Parameters:
WIDTH, 32, datapath width in bits; even, >=8.
SHW, $clog2(WIDTH), shift-amount width; shift ops use A[SHW-1:0].

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  issue strobe for sequential ops (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
ALUCtrl  input  5  operation select
A  input  WIDTH  operand A (rs / shift amount)
B  input  WIDTH  operand B (rt / immediate)
result  output  WIDTH  combinational result
Zero  output  1  result == 0
Sign  output  1  result[WIDTH-1]
O  output  1  signed overflow; ADD/SUB only, else 0
busy  output  1  MDU iterating
done  output  1  one-cycle pulse when HI/LO are written by MULT*/DIV*
div_zero  output  1  valid with done; divisor was 0
stall  output  1  busy & (ALUCtrl is MFHI/MFLO or any MDU op)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Encodings 00000-01101 (ADD, ADDU, SUB, SUBU, AND, OR, NOR, XOR, SLT, SLTU, SLL, SRL, SRA, LUI):
  - Purely combinational.
  - SLL/SRL/SRA shift B by A[SHW-1:0]; LUI = {B[15:0], zeros}, valid for WIDTH>=16.
  - SLT is a true signed compare. SLTU is an unsigned compare.
  - O for ADD = (A.msb==B.msb) & (sum.msb!=A.msb). O for SUB = (A.msb!=B.msb) & (diff.msb!=A.msb).
  - O is computed from the internal sum/diff, never from the result register. No latches.
- MDU encodings:
  - 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU.
  - 10100 MFHI (result=hi), 10101 MFLO (result=lo).
  - 10110 MTHI, 10111 MTLO: result=A; register written at the clock edge with start=1 & busy=0.
- Undefined encodings: result=0, no state change.
- Accept rule: an MDU op is accepted at an edge with start=1 & busy=0. start while busy=1 is ignored with no effect.
- FSM IDLE -> CALC -> FIX -> IDLE:
  - Accept MULT*/DIV*: latch magnitudes (signed ops take abs), record sign flags, counter=0, busy=1.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles.
  - FIX (1 cycle): apply sign correction and write hi/lo.
  - Next cycle: IDLE, busy=0, done=1, div_zero valid.
  - busy is high for WIDTH+1 cycles. done is at cycle WIDTH+2 after the accept edge.
- Multiply: {hi,lo} = 2*WIDTH-bit product; signed for MULT, unsigned for MULTU.
- Divide results:
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Signed MIN / -1 gives lo=MIN, hi=0.
- Divisor 0: lo = all ones, hi = dividend (unchanged A), div_zero=1 during done.
- hi/lo are not modified while busy. MFHI/MFLO while busy return stale values, and stall=1.
- Reset (any time, including mid-CALC):
  - FSM -> IDLE.
  - busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
  - The aborted op leaves no trace.

Test Plan:
- WIDTH=32, ADD A=7FFFFFFF B=00000001 -> result=80000000, O=1, Sign=1, Zero=0; ADDU same operands -> O=0.
- SLT A=FFFFFFFF B=00000001 -> result=1; SLTU same -> 0; SRA A=4 B=F0000000 -> FF000000.
- MULT A=FFFFFFFD(-3) B=5, start 1 cycle -> busy 33 cycles, done at cycle 34, hi=FFFFFFFF, lo=FFFFFFF1; MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 5/0 -> lo=FFFFFFFF, hi=5, div_zero=1 with done.
- MTLO A=1234 then MFLO -> 1234; MULT in flight, second start with DIV at cycle 5 -> ignored, final hi/lo match MULT only; MFHI during busy -> stall=1.
- rst asserted at CALC cycle 10 -> busy=0, hi=lo=0 immediately; a new MULTU 6*7 after release -> lo=42, hi=0.
